sc_statemachine_move: RTL and testbench

// - Parametrised player-movement controller for the Frogger grid: decodes active-low direction/start buttons.
// - Owns the player column/row position and clamps it at all four grid edges.
// - Supports level reset/next-level requests and optional auto-repeat while a direction is held.
// - Sits between the debounced button inputs and the player-sprite/collision logic; replaces shift/load-style point control.

---
 rtl/sc_move_defs.sv | 23 ++
 rtl/sc_move_repeat_timer.sv | 63 ++++++
 rtl/sc_statemachine_move.sv | 217 +++++++++++++++++++++
 tb/tb_sc_statemachine_move.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_move_defs.sv
// Shared definitions for the Frogger player-movement controller.
// Holds the FSM state encoding, the direction codes driven on dir_Out and a
// small helper used to size the auto-repeat counter.
package sc_move_defs;

    typedef enum logic [2:0] {
        StReset = 3'd0,
        StCheck = 3'd1,
        StInit  = 3'd2,
        StMove  = 3'd3,
        StHold  = 3'd4
    } state_e;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sc_move_repeat_timer.sv
// Auto-repeat interval counter for the movement controller.
// Counts enabled cycles and flags the terminal count; the terminal value is
// HOLD_CYCLES-1 for the first repeat and REPEAT_CYCLES-1 for later ones.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   clr_i   synchronous clear (wins over enable)
//   en_i    count enable
//   rep_i   0: first-repeat interval, 1: subsequent-repeat interval
//   tc_o    terminal count reached this cycle (only while enabled)
module sc_move_repeat_timer
    import sc_move_defs::*;
#(
    parameter int unsigned HOLD_CYCLES   = 0,
    parameter int unsigned REPEAT_CYCLES = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    input  logic rep_i,
    output logic tc_o
);

    localparam int unsigned RepEff  = (REPEAT_CYCLES == 0) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned MaxTerm = max_u(HOLD_CYCLES, RepEff);
    // Keep at least one bit so the counter exists even with auto-repeat disabled.
    localparam int unsigned CntW    = (MaxTerm == 0) ? 1 : $clog2(MaxTerm + 1);

    localparam logic [CntW-1:0] HoldLast = CntW'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] RepLast  = CntW'((RepEff == 0) ? 0 : RepEff - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] last;
    logic            tc;

    always_comb begin
        last  = rep_i ? RepLast : HoldLast;
        tc    = en_i && (cnt_q == last);
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (tc) begin
                cnt_d = '0;
            end else if (cnt_q != {CntW{1'b1}}) begin
                // Saturate rather than wrap.
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    assign tc_o = tc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sc_statemachine_move.sv
// Player-movement controller for the Frogger grid.
// Decodes active-low direction/start buttons, owns the player position with
// clamping at all four grid edges, handles level restart/next-level requests
// and optional auto-repeat while a direction stays held.
// Ports:
//   SC_STATEMACHINEMOVE_CLOCK_50            system clock
//   SC_STATEMACHINEMOVE_RESET_InLow         asynchronous active-low reset
//   SC_STATEMACHINEMOVE_*Button_InLow       start/up/down/left/right, active low
//   SC_STATEMACHINEMOVE_resetLevel_In       level-restart pulse
//   SC_STATEMACHINEMOVE_nextLevel_In        level-complete pulse
//   SC_STATEMACHINEMOVE_col_Out/row_Out     player position
//   SC_STATEMACHINEMOVE_clear_OutLow        one-cycle low pulse in INIT
//   SC_STATEMACHINEMOVE_moved_Out           one-cycle pulse after a real move
//   SC_STATEMACHINEMOVE_dir_Out             last accepted direction
//   SC_STATEMACHINEMOVE_atGoal_Out          player is on row 0
module sc_statemachine_move
    import sc_move_defs::*;
#(
    parameter int unsigned COLS          = 8,
    parameter int unsigned ROWS          = 16,
    parameter int unsigned START_COL     = 3,
    parameter int unsigned START_ROW     = 15,
    parameter int unsigned HOLD_CYCLES   = 0,
    parameter int unsigned REPEAT_CYCLES = 0,
    localparam int unsigned CW           = $clog2(COLS),
    localparam int unsigned RW           = $clog2(ROWS)
) (
    input  logic          SC_STATEMACHINEMOVE_CLOCK_50,
    input  logic          SC_STATEMACHINEMOVE_RESET_InLow,
    input  logic          SC_STATEMACHINEMOVE_startButton_InLow,
    input  logic          SC_STATEMACHINEMOVE_upButton_InLow,
    input  logic          SC_STATEMACHINEMOVE_downButton_InLow,
    input  logic          SC_STATEMACHINEMOVE_leftButton_InLow,
    input  logic          SC_STATEMACHINEMOVE_rightButton_InLow,
    input  logic          SC_STATEMACHINEMOVE_resetLevel_In,
    input  logic          SC_STATEMACHINEMOVE_nextLevel_In,
    output logic [CW-1:0] SC_STATEMACHINEMOVE_col_Out,
    output logic [RW-1:0] SC_STATEMACHINEMOVE_row_Out,
    output logic          SC_STATEMACHINEMOVE_clear_OutLow,
    output logic          SC_STATEMACHINEMOVE_moved_Out,
    output logic [1:0]    SC_STATEMACHINEMOVE_dir_Out,
    output logic          SC_STATEMACHINEMOVE_atGoal_Out
);

    localparam bit            AutoRep  = (HOLD_CYCLES != 0);
    localparam logic [CW-1:0] StartCol = CW'(START_COL);
    localparam logic [RW-1:0] StartRow = RW'(START_ROW);
    localparam logic [CW-1:0] LastCol  = CW'(COLS - 1);
    localparam logic [RW-1:0] LastRow  = RW'(ROWS - 1);

    logic clk, rst_n;
    logic btn_start, btn_up, btn_dn, btn_lf, btn_rt;
    logic lvl_req, any_dir, any_btn;

    assign clk       = SC_STATEMACHINEMOVE_CLOCK_50;
    assign rst_n     = SC_STATEMACHINEMOVE_RESET_InLow;
    assign btn_start = ~SC_STATEMACHINEMOVE_startButton_InLow;
    assign btn_up    = ~SC_STATEMACHINEMOVE_upButton_InLow;
    assign btn_dn    = ~SC_STATEMACHINEMOVE_downButton_InLow;
    assign btn_lf    = ~SC_STATEMACHINEMOVE_leftButton_InLow;
    assign btn_rt    = ~SC_STATEMACHINEMOVE_rightButton_InLow;
    assign lvl_req   = SC_STATEMACHINEMOVE_resetLevel_In | SC_STATEMACHINEMOVE_nextLevel_In;
    assign any_dir   = btn_up | btn_dn | btn_lf | btn_rt;
    assign any_btn   = any_dir | btn_start;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    dir_q, dir_d;
    logic          rep_q, rep_d;    // first repeat already fired during this hold
    logic          mute_q, mute_d;  // repeats suppressed after INIT until full release

    logic tmr_clr, tmr_en, tmr_tc;

    // Direction decode with fixed priority; req_ok is the edge-clamp verdict.
    logic          req_valid, req_ok;
    logic [1:0]    req_dir;
    logic [CW-1:0] col_step;
    logic [RW-1:0] row_step;

    always_comb begin
        req_valid = 1'b1;
        req_ok    = 1'b0;
        req_dir   = DIR_UP;
        col_step  = col_q;
        row_step  = row_q;
        if (btn_up) begin
            req_ok   = (row_q != '0);
            row_step = row_q - RW'(1);
        end else if (btn_dn) begin
            req_dir  = DIR_DOWN;
            req_ok   = (row_q != LastRow);
            row_step = row_q + RW'(1);
        end else if (btn_lf) begin
            req_dir  = DIR_LEFT;
            req_ok   = (col_q != '0);
            col_step = col_q - CW'(1);
        end else if (btn_rt) begin
            req_dir  = DIR_RIGHT;
            req_ok   = (col_q != LastCol);
            col_step = col_q + CW'(1);
        end else begin
            req_valid = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        dir_d   = dir_q;
        rep_d   = rep_q;
        mute_d  = mute_q;
        tmr_clr = 1'b1;
        tmr_en  = 1'b0;
        unique case (state_q)
            StReset: begin
                state_d = StCheck;
            end
            StCheck: begin
                rep_d  = 1'b0;
                mute_d = 1'b0;
                if (lvl_req || btn_start) begin
                    state_d = StInit;
                    col_d   = StartCol;
                    row_d   = StartRow;
                    mute_d  = 1'b1;
                end else if (req_valid) begin
                    if (req_ok) begin
                        state_d = StMove;
                        col_d   = col_step;
                        row_d   = row_step;
                        dir_d   = req_dir;
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StInit: begin
                state_d = StHold;
            end
            StMove: begin
                // The repeat interval is measured from the move itself.
                tmr_clr = 1'b0;
                tmr_en  = AutoRep && any_dir && !mute_q;
                state_d = StHold;
            end
            StHold: begin
                tmr_clr = 1'b0;
                if (lvl_req) begin
                    state_d = StInit;
                    col_d   = StartCol;
                    row_d   = StartRow;
                    rep_d   = 1'b0;
                    mute_d  = 1'b1;
                    tmr_clr = 1'b1;
                end else if (!any_btn) begin
                    state_d = StCheck;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_en = AutoRep && any_dir && !mute_q;
                    if (tmr_tc) begin
                        rep_d = 1'b1;
                        if (req_ok) begin
                            state_d = StMove;
                            col_d   = col_step;
                            row_d   = row_step;
                            dir_d   = req_dir;
                        end
                    end
                end
            end
            default: begin
                state_d = StCheck;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StReset;
            col_q   <= StartCol;
            row_q   <= StartRow;
            dir_q   <= DIR_UP;
            rep_q   <= 1'b0;
            mute_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            dir_q   <= dir_d;
            rep_q   <= rep_d;
            mute_q  <= mute_d;
        end
    end

    sc_move_repeat_timer #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_timer (
        .clk_i (clk),
        .rst_ni(rst_n),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .rep_i (rep_q),
        .tc_o  (tmr_tc)
    );

    // Moore outputs; any unknown state leaves them inactive.
    assign SC_STATEMACHINEMOVE_col_Out      = col_q;
    assign SC_STATEMACHINEMOVE_row_Out      = row_q;
    assign SC_STATEMACHINEMOVE_dir_Out      = dir_q;
    assign SC_STATEMACHINEMOVE_clear_OutLow = (state_q != StInit);
    assign SC_STATEMACHINEMOVE_moved_Out    = (state_q == StMove);
    assign SC_STATEMACHINEMOVE_atGoal_Out   = (row_q == '0);

endmodule

// File: tb/tb_sc_statemachine_move.sv
// Bench for sc_statemachine_move: one instance with auto-repeat off and one
// with HOLD_CYCLES=4 / REPEAT_CYCLES=2 share the same button stimulus and are
// compared every cycle against a behavioural model of the player controller.
module tb_sc_statemachine_move;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic st, up, dn, lf, rt, rl, nl;  // active-high view of the buttons

    logic [2:0] a_col, b_col;
    logic [3:0] a_row, b_row;
    logic [1:0] a_dir, b_dir;
    logic       a_clr, b_clr, a_mov, b_mov, a_goal, b_goal;

    int total = 0;
    int bad   = 0;

    sc_statemachine_move dut_a (
        .SC_STATEMACHINEMOVE_CLOCK_50          (clk),
        .SC_STATEMACHINEMOVE_RESET_InLow       (rst_n),
        .SC_STATEMACHINEMOVE_startButton_InLow (~st),
        .SC_STATEMACHINEMOVE_upButton_InLow    (~up),
        .SC_STATEMACHINEMOVE_downButton_InLow  (~dn),
        .SC_STATEMACHINEMOVE_leftButton_InLow  (~lf),
        .SC_STATEMACHINEMOVE_rightButton_InLow (~rt),
        .SC_STATEMACHINEMOVE_resetLevel_In     (rl),
        .SC_STATEMACHINEMOVE_nextLevel_In      (nl),
        .SC_STATEMACHINEMOVE_col_Out           (a_col),
        .SC_STATEMACHINEMOVE_row_Out           (a_row),
        .SC_STATEMACHINEMOVE_clear_OutLow      (a_clr),
        .SC_STATEMACHINEMOVE_moved_Out         (a_mov),
        .SC_STATEMACHINEMOVE_dir_Out           (a_dir),
        .SC_STATEMACHINEMOVE_atGoal_Out        (a_goal)
    );

    sc_statemachine_move #(
        .HOLD_CYCLES  (4),
        .REPEAT_CYCLES(2)
    ) dut_b (
        .SC_STATEMACHINEMOVE_CLOCK_50          (clk),
        .SC_STATEMACHINEMOVE_RESET_InLow       (rst_n),
        .SC_STATEMACHINEMOVE_startButton_InLow (~st),
        .SC_STATEMACHINEMOVE_upButton_InLow    (~up),
        .SC_STATEMACHINEMOVE_downButton_InLow  (~dn),
        .SC_STATEMACHINEMOVE_leftButton_InLow  (~lf),
        .SC_STATEMACHINEMOVE_rightButton_InLow (~rt),
        .SC_STATEMACHINEMOVE_resetLevel_In     (rl),
        .SC_STATEMACHINEMOVE_nextLevel_In      (nl),
        .SC_STATEMACHINEMOVE_col_Out           (b_col),
        .SC_STATEMACHINEMOVE_row_Out           (b_row),
        .SC_STATEMACHINEMOVE_clear_OutLow      (b_clr),
        .SC_STATEMACHINEMOVE_moved_Out         (b_mov),
        .SC_STATEMACHINEMOVE_dir_Out           (b_dir),
        .SC_STATEMACHINEMOVE_atGoal_Out        (b_goal)
    );

    // ---------------- behavioural model ----------------
    // Phases: just out of reset, waiting for a press, clearing the level,
    // showing a move pulse, and waiting for release (with optional repeats).
    localparam int PH_BOOT  = 0;
    localparam int PH_IDLE  = 1;
    localparam int PH_CLEAR = 2;
    localparam int PH_STEP  = 3;
    localparam int PH_WAIT  = 4;

    int m_ph[2], m_col[2], m_row[2], m_dir[2], m_held[2];
    bit m_rep[2], m_mute[2];

    function automatic int hold_of(input int i);
        return (i == 0) ? 0 : 4;
    endfunction

    function automatic int period_of(input int i, input bit later);
        return later ? ((i == 0) ? 0 : 2) : hold_of(i);
    endfunction

    function automatic int first_dir();
        if (up) return 0;
        if (dn) return 1;
        if (lf) return 2;
        if (rt) return 3;
        return -1;
    endfunction

    task automatic model_reset(input int i);
        m_ph[i] = PH_BOOT; m_col[i] = 3; m_row[i] = 15; m_dir[i] = 0;
        m_held[i] = 0; m_rep[i] = 1'b0; m_mute[i] = 1'b0;
    endtask

    task automatic go_clear(input int i);
        m_ph[i] = PH_CLEAR; m_col[i] = 3; m_row[i] = 15;
        m_held[i] = 0; m_rep[i] = 1'b0; m_mute[i] = 1'b1;
    endtask

    // Attempt a step in direction d; stays inside an 8x16 grid.
    task automatic try_move(input int i, input int d, output bit ok);
        int nc, nr;
        nc = m_col[i] + ((d == 2) ? -1 : (d == 3) ? 1 : 0);
        nr = m_row[i] + ((d == 0) ? -1 : (d == 1) ? 1 : 0);
        ok = (nc >= 0) && (nc <= 7) && (nr >= 0) && (nr <= 15);
        if (ok) begin
            m_col[i] = nc; m_row[i] = nr; m_dir[i] = d;
        end
    endtask

    task automatic model_step(input int i);
        int d, last;
        bit ok, counting;
        if (!rst_n) begin
            model_reset(i);
            return;
        end
        d        = first_dir();
        last     = period_of(i, m_rep[i]) - 1;
        counting = (hold_of(i) > 0) && (d >= 0) && !m_mute[i];
        case (m_ph[i])
            PH_BOOT: m_ph[i] = PH_IDLE;
            PH_IDLE: begin
                m_held[i] = 0; m_rep[i] = 1'b0; m_mute[i] = 1'b0;
                if (rl || nl || st) go_clear(i);
                else if (d >= 0) begin
                    try_move(i, d, ok);
                    m_ph[i] = ok ? PH_STEP : PH_WAIT;
                end
            end
            PH_CLEAR: m_ph[i] = PH_WAIT;
            PH_STEP: begin
                if (counting) m_held[i] = (m_held[i] == last) ? 0 : m_held[i] + 1;
                m_ph[i] = PH_WAIT;
            end
            PH_WAIT: begin
                if (rl || nl) go_clear(i);
                else if (d < 0 && !st) begin
                    m_ph[i] = PH_IDLE; m_held[i] = 0;
                end else if (counting) begin
                    if (m_held[i] == last) begin
                        m_held[i] = 0; m_rep[i] = 1'b1;
                        try_move(i, d, ok);
                        if (ok) m_ph[i] = PH_STEP;
                    end else begin
                        m_held[i] = m_held[i] + 1;
                    end
                end
            end
            default: ;
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk("col", i, (i == 0) ? 32'(a_col) : 32'(b_col), m_col[i]);
            chk("row", i, (i == 0) ? 32'(a_row) : 32'(b_row), m_row[i]);
            chk("dir", i, (i == 0) ? 32'(a_dir) : 32'(b_dir), m_dir[i]);
            chk("moved", i, (i == 0) ? 32'(a_mov) : 32'(b_mov), (m_ph[i] == PH_STEP) ? 1 : 0);
            chk("clear_n", i, (i == 0) ? 32'(a_clr) : 32'(b_clr), (m_ph[i] == PH_CLEAR) ? 0 : 1);
            chk("goal", i, (i == 0) ? 32'(a_goal) : 32'(b_goal), (m_row[i] == 0) ? 1 : 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic release_all();
        {st, up, dn, lf, rt, rl, nl} = '0;
    endtask

    initial begin
        int exp_row;
        rst_n = 1'b0;
        release_all();
        model_reset(0);
        model_reset(1);
        repeat (2) tick();
        chk("rst_col", 0, a_col, 3);
        chk("rst_row", 0, a_row, 15);
        chk("rst_clear_n", 0, a_clr, 1);
        rst_n = 1'b1;
        tick();

        // Single up press: one move, then nothing more while held.
        up = 1'b1;
        tick();
        chk("up_row", 0, a_row, 14);
        chk("up_moved", 0, a_mov, 1);
        chk("up_dir", 0, a_dir, 0);
        repeat (2) begin
            tick();
            chk("up_no_more", 0, a_mov, 0);
        end
        up = 1'b0;
        repeat (2) tick();

        // Walk to the left edge, then hold left against it.
        repeat (3) begin
            lf = 1'b1; tick();
            lf = 1'b0; tick(); tick();
        end
        chk("left_edge", 0, a_col, 0);
        lf = 1'b1;
        repeat (5) begin
            tick();
            chk("left_blocked_col", 0, a_col, 0);
            chk("left_blocked_mov", 0, a_mov, 0);
        end
        lf = 1'b0; tick();
        rt = 1'b1; tick();
        chk("right_col", 0, a_col, 1);
        rt = 1'b0; tick(); tick();

        // resetLevel beats a simultaneous up press.
        rl = 1'b1; up = 1'b1;
        tick();
        chk("lvl_clear_n", 0, a_clr, 0);
        chk("lvl_row", 0, a_row, 15);
        chk("lvl_col", 0, a_col, 3);
        chk("lvl_mov", 0, a_mov, 0);
        release_all();
        tick();
        chk("lvl_clear_once", 0, a_clr, 1);
        tick();

        // Auto-repeat: move at cycle 1, then every 2nd cycle from cycle 5 until row 0.
        up = 1'b1;
        exp_row = 15;
        for (int k = 1; k <= 40; k++) begin
            bit mv;
            mv = (k == 1) || (k >= 5 && k <= 31 && ((k - 5) % 2) == 0);
            if (mv) exp_row--;
            tick();
            chk("rep_moved", 1, b_mov, mv);
            chk("rep_row", 1, b_row, exp_row);
        end
        chk("rep_goal", 1, b_goal, 1);
        chk("norep_row", 0, a_row, 14);
        up = 1'b0;
        tick(); tick();

        // nextLevel while down is held in HOLD: restart and no repeats until release.
        dn = 1'b1;
        tick(); tick();
        nl = 1'b1;
        tick();
        chk("nl_clear_n", 1, b_clr, 0);
        chk("nl_row", 1, b_row, 15);
        nl = 1'b0;
        repeat (12) begin
            tick();
            chk("nl_no_repeat", 1, b_mov, 0);
        end
        dn = 1'b0;
        tick();

        // Asynchronous reset in the middle of a hold at row 7.
        up = 1'b1;
        for (int k = 0; k < 60 && m_row[1] != 7; k++) tick();
        chk("reach_row7", 1, b_row, 7);
        tick();
        #2;
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        chk("arst_col", 1, b_col, 3);
        chk("arst_row", 1, b_row, 15);
        chk("arst_clear_n", 1, b_clr, 1);
        chk("arst_moved", 1, b_mov, 0);
        check_all();
        up = 1'b0;
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        up = 1'b1;
        tick();
        chk("post_rst_row", 0, a_row, 14);
        chk("post_rst_mov", 1, b_mov, 1);
        up = 1'b0;
        tick(); tick();

        // Randomised button bursts with occasional level pulses.
        for (int b = 0; b < 150; b++) begin
            int r, len;
            r   = $urandom_range(0, 9);
            len = $urandom_range(1, 10);
            {st, up, dn, lf, rt} = '0;
            case (r)
                0: up = 1'b1;
                1: dn = 1'b1;
                2: lf = 1'b1;
                3: rt = 1'b1;
                4: st = 1'b1;
                8: begin
                    up = 1'($urandom_range(0, 1));
                    rt = 1'($urandom_range(0, 1));
                    dn = 1'($urandom_range(0, 1));
                end
                9: {st, up, dn, lf, rt} = 5'($urandom);
                default: ;
            endcase
            for (int k = 0; k < len; k++) begin
                rl = ($urandom_range(0, 29) == 0);
                nl = ($urandom_range(0, 29) == 0);
                tick();
            end
        end
        release_all();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
